// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and the entry record for the in-order reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 6;
  localparam int ARCH_W    = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [ARCH_W-1:0] arch;
    logic [PREG_W-1:0] phys;
    logic [PREG_W-1:0] old_phys;
    logic              regwrite;
    logic              is_store;
    logic [31:0]       pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Wrapping ring pointer whose MSB is the lap bit; clear takes priority over increment.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_d;
  logic [W-1:0] ptr_q;

  // next pointer value
  always_comb begin
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates in program order, completes by tag, retires one finished head entry per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              alloc_valid,
  input  logic [ARCH_W-1:0] alloc_arch_reg,
  input  logic [PREG_W-1:0] alloc_phys_reg,
  input  logic [PREG_W-1:0] alloc_old_phys,
  input  logic              alloc_regwrite,
  input  logic              alloc_is_store,
  input  logic [31:0]       alloc_pc,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              rob_halt,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  output logic              commit_valid,
  output logic [ARCH_W-1:0] commit_arch_reg,
  output logic [PREG_W-1:0] commit_phys_reg,
  output logic              commit_regwrite,
  output logic [31:0]       commit_pc,
  output logic              store_commit,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_phys_reg,
  output logic [TAG_W:0]    count
);

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  rob_entry_t        head_entry_s;
  rob_entry_t        new_entry_s;
  logic [TAG_W:0]    head_s;
  logic [TAG_W:0]    tail_s;
  logic [TAG_W-1:0]  head_idx_s;
  logic [TAG_W-1:0]  tail_idx_s;
  logic              full_s;
  logic              alloc_fire_s;
  logic              commit_fire_s;

  logic              commit_valid_d,    commit_valid_q;
  logic [ARCH_W-1:0] commit_arch_reg_d, commit_arch_reg_q;
  logic [PREG_W-1:0] commit_phys_reg_d, commit_phys_reg_q;
  logic              commit_regwrite_d, commit_regwrite_q;
  logic [31:0]       commit_pc_d,       commit_pc_q;
  logic              store_commit_d,    store_commit_q;
  logic              free_valid_d,      free_valid_q;
  logic [PREG_W-1:0] free_phys_reg_d,   free_phys_reg_q;

  rob_ptr #(.W(TAG_W + 1)) u_head (
    .CLK   (CLK),
    .RESET (RESET),
    .clr_i (FLUSH),
    .inc_i (commit_fire_s),
    .ptr_o (head_s)
  );

  rob_ptr #(.W(TAG_W + 1)) u_tail (
    .CLK   (CLK),
    .RESET (RESET),
    .clr_i (FLUSH),
    .inc_i (alloc_fire_s),
    .ptr_o (tail_s)
  );

  assign head_idx_s    = head_s[TAG_W-1:0];
  assign tail_idx_s    = tail_s[TAG_W-1:0];
  assign full_s        = (head_idx_s == tail_idx_s) && (head_s[TAG_W] != tail_s[TAG_W]);
  assign alloc_ready   = !full_s;
  assign rob_halt      = full_s;
  assign alloc_tag     = tail_idx_s;
  assign count         = tail_s - head_s;
  assign alloc_fire_s  = alloc_valid && !full_s;
  assign head_entry_s  = entries_q[head_idx_s];
  // done is only read from the registered array, so completion never bypasses into commit
  assign commit_fire_s = head_entry_s.valid && head_entry_s.done;

  assign new_entry_s = '{valid:    1'b1,
                         done:     1'b0,
                         arch:     alloc_arch_reg,
                         phys:     alloc_phys_reg,
                         old_phys: alloc_old_phys,
                         regwrite: alloc_regwrite,
                         is_store: alloc_is_store,
                         pc:       alloc_pc};

  // per-entry next state: flush, then allocate / retire / complete
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (FLUSH) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end else if (alloc_fire_s && (tail_idx_s == TAG_W'(i))) begin
        entries_d[i] = new_entry_s;
      end else if (commit_fire_s && (head_idx_s == TAG_W'(i))) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end else if (complete_valid && (complete_tag == TAG_W'(i)) && entries_q[i].valid) begin
        entries_d[i].done = 1'b1;
      end else begin
        entries_d[i] = entries_q[i];
      end
    end
  end

  // entry storage
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // commit and free-list outputs for the next edge
  always_comb begin
    commit_valid_d    = 1'b0;
    commit_arch_reg_d = '0;
    commit_phys_reg_d = '0;
    commit_regwrite_d = 1'b0;
    commit_pc_d       = 32'd0;
    store_commit_d    = 1'b0;
    free_valid_d      = 1'b0;
    free_phys_reg_d   = '0;
    if (commit_fire_s && !FLUSH) begin
      commit_valid_d    = 1'b1;
      commit_arch_reg_d = head_entry_s.arch;
      commit_phys_reg_d = head_entry_s.phys;
      commit_regwrite_d = head_entry_s.regwrite;
      commit_pc_d       = head_entry_s.pc;
      store_commit_d    = head_entry_s.is_store;
      free_valid_d      = head_entry_s.regwrite && (head_entry_s.arch != 5'd0);
      free_phys_reg_d   = head_entry_s.old_phys;
    end else begin
      commit_valid_d    = 1'b0;
    end
  end

  // registered commit and free-list outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      commit_valid_q    <= 1'b0;
      commit_arch_reg_q <= '0;
      commit_phys_reg_q <= '0;
      commit_regwrite_q <= 1'b0;
      commit_pc_q       <= 32'd0;
      store_commit_q    <= 1'b0;
      free_valid_q      <= 1'b0;
      free_phys_reg_q   <= '0;
    end else begin
      commit_valid_q    <= commit_valid_d;
      commit_arch_reg_q <= commit_arch_reg_d;
      commit_phys_reg_q <= commit_phys_reg_d;
      commit_regwrite_q <= commit_regwrite_d;
      commit_pc_q       <= commit_pc_d;
      store_commit_q    <= store_commit_d;
      free_valid_q      <= free_valid_d;
      free_phys_reg_q   <= free_phys_reg_d;
    end
  end

  assign commit_valid    = commit_valid_q;
  assign commit_arch_reg = commit_arch_reg_q;
  assign commit_phys_reg = commit_phys_reg_q;
  assign commit_regwrite = commit_regwrite_q;
  assign commit_pc       = commit_pc_q;
  assign store_commit    = store_commit_q;
  assign free_valid      = free_valid_q;
  assign free_phys_reg   = free_phys_reg_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: ordering, full/wrap, flush, reset and commit side effects.
module tb_reorder_buffer;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        alloc_valid;
  logic [4:0]  alloc_arch_reg;
  logic [5:0]  alloc_phys_reg;
  logic [5:0]  alloc_old_phys;
  logic        alloc_regwrite;
  logic        alloc_is_store;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        rob_halt;
  logic        complete_valid;
  logic [3:0]  complete_tag;
  logic        commit_valid;
  logic [4:0]  commit_arch_reg;
  logic [5:0]  commit_phys_reg;
  logic        commit_regwrite;
  logic [31:0] commit_pc;
  logic        store_commit;
  logic        free_valid;
  logic [5:0]  free_phys_reg;
  logic [4:0]  count;

  int tests_run    = 0;
  int tests_failed = 0;

  reorder_buffer dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .FLUSH           (FLUSH),
    .alloc_valid     (alloc_valid),
    .alloc_arch_reg  (alloc_arch_reg),
    .alloc_phys_reg  (alloc_phys_reg),
    .alloc_old_phys  (alloc_old_phys),
    .alloc_regwrite  (alloc_regwrite),
    .alloc_is_store  (alloc_is_store),
    .alloc_pc        (alloc_pc),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .rob_halt        (rob_halt),
    .complete_valid  (complete_valid),
    .complete_tag    (complete_tag),
    .commit_valid    (commit_valid),
    .commit_arch_reg (commit_arch_reg),
    .commit_phys_reg (commit_phys_reg),
    .commit_regwrite (commit_regwrite),
    .commit_pc       (commit_pc),
    .store_commit    (store_commit),
    .free_valid      (free_valid),
    .free_phys_reg   (free_phys_reg),
    .count           (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_alloc(input logic [4:0] arch, input logic [5:0] phys, input logic [5:0] old_p,
                           input logic rw, input logic st, input logic [31:0] pc);
    alloc_valid    = 1'b1;
    alloc_arch_reg = arch;
    alloc_phys_reg = phys;
    alloc_old_phys = old_p;
    alloc_regwrite = rw;
    alloc_is_store = st;
    alloc_pc       = pc;
  endtask

  task automatic do_alloc(input logic [4:0] arch, input logic [5:0] phys, input logic [5:0] old_p,
                          input logic rw, input logic st, input logic [31:0] pc);
    set_alloc(arch, phys, old_p, rw, st, pc);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input logic [3:0] tag);
    complete_valid = 1'b1;
    complete_tag   = tag;
    tick();
    complete_valid = 1'b0;
  endtask

  task automatic do_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; FLUSH = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0; complete_tag = 4'd0;
    alloc_arch_reg = 5'd0; alloc_phys_reg = 6'd0; alloc_old_phys = 6'd0;
    alloc_regwrite = 1'b0; alloc_is_store = 1'b0; alloc_pc = 32'd0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;

    // reset then idle
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_ready", alloc_ready, 1'b1);
      check("idle_tag", alloc_tag, 4'd0);
      check("idle_count", count, 5'd0);
      check("idle_commit", commit_valid, 1'b0);
    end

    // out-of-order completion, in-order commit
    do_alloc(5'd8,  6'd33, 6'd8,  1'b1, 1'b0, 32'h100);
    do_alloc(5'd9,  6'd34, 6'd9,  1'b1, 1'b0, 32'h104);
    do_alloc(5'd10, 6'd35, 6'd10, 1'b1, 1'b0, 32'h108);
    check("ooo_count3", count, 5'd3);
    check("ooo_tag3", alloc_tag, 4'd3);
    do_complete(4'd2);
    check("ooo_no_commit_a", commit_valid, 1'b0);
    do_complete(4'd0);
    check("ooo_no_commit_b", commit_valid, 1'b0);
    do_complete(4'd1);
    check("c0_valid", commit_valid, 1'b1);
    check("c0_phys", commit_phys_reg, 6'd33);
    check("c0_arch", commit_arch_reg, 5'd8);
    check("c0_free_v", free_valid, 1'b1);
    check("c0_free", free_phys_reg, 6'd8);
    check("c0_pc", commit_pc, 32'h100);
    tick();
    check("c1_valid", commit_valid, 1'b1);
    check("c1_phys", commit_phys_reg, 6'd34);
    check("c1_free", free_phys_reg, 6'd9);
    tick();
    check("c2_valid", commit_valid, 1'b1);
    check("c2_phys", commit_phys_reg, 6'd35);
    check("c2_free", free_phys_reg, 6'd10);
    tick();
    check("c3_idle", commit_valid, 1'b0);
    check("c3_count", count, 5'd0);

    // flush with alloc and complete in the same cycle (tags 3..7 held)
    for (int i = 0; i < 5; i++) do_alloc(5'd1, 6'd40, 6'd41, 1'b1, 1'b0, 32'h200);
    check("fl_count5", count, 5'd5);
    set_alloc(5'd2, 6'd42, 6'd43, 1'b1, 1'b0, 32'h300);
    complete_valid = 1'b1; complete_tag = 4'd3; FLUSH = 1'b1;
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b0; FLUSH = 1'b0;
    check("fl_count", count, 5'd0);
    check("fl_tag", alloc_tag, 4'd0);
    check("fl_commit", commit_valid, 1'b0);
    do_complete(4'd3);
    tick();
    check("fl_late_commit", commit_valid, 1'b0);
    check("fl_late_count", count, 5'd0);

    // fill to 16, reject the 17th, wrap
    for (int i = 0; i < 16; i++)
      do_alloc(5'(i + 1), 6'(16 + i), 6'(i), 1'b1, 1'b0, 32'h1000 + 32'(4 * i));
    check("full_ready", alloc_ready, 1'b0);
    check("full_halt", rob_halt, 1'b1);
    check("full_count", count, 5'd16);
    do_alloc(5'd31, 6'd63, 6'd62, 1'b1, 1'b1, 32'hDEAD);
    check("full17_count", count, 5'd16);
    check("full17_ready", alloc_ready, 1'b0);
    do_complete(4'd0);
    check("full_nocommit_yet", commit_valid, 1'b0);
    tick();
    check("wrap_commit", commit_valid, 1'b1);
    check("wrap_phys", commit_phys_reg, 6'd16);
    check("wrap_pc", commit_pc, 32'h1000);
    check("wrap_store", store_commit, 1'b0);
    check("wrap_count", count, 5'd15);
    check("wrap_ready", alloc_ready, 1'b1);
    check("wrap_tag", alloc_tag, 4'd0);

    // full with head done and a same-cycle allocation
    do_alloc(5'd20, 6'd50, 6'd40, 1'b1, 1'b0, 32'h2000);
    check("fc_count16", count, 5'd16);
    do_complete(4'd1);
    set_alloc(5'd21, 6'd51, 6'd41, 1'b1, 1'b0, 32'h3000);
    tick();
    check("fc_commit", commit_valid, 1'b1);
    check("fc_phys", commit_phys_reg, 6'd17);
    check("fc_count15", count, 5'd15);
    check("fc_ready", alloc_ready, 1'b1);
    check("fc_tag1", alloc_tag, 4'd1);
    tick();
    alloc_valid = 1'b0;
    check("fc_accept_count", count, 5'd16);
    check("fc_accept_tag", alloc_tag, 4'd2);
    check("fc_accept_nocommit", commit_valid, 1'b0);

    // arch 0 write and a store
    do_flush();
    check("x0_flush_count", count, 5'd0);
    do_alloc(5'd0, 6'd5, 6'd6, 1'b1, 1'b0, 32'h400);
    do_alloc(5'd3, 6'd7, 6'd9, 1'b0, 1'b1, 32'h404);
    do_complete(4'd0);
    do_complete(4'd1);
    check("x0_commit", commit_valid, 1'b1);
    check("x0_free_v", free_valid, 1'b0);
    check("x0_rw", commit_regwrite, 1'b1);
    check("x0_store", store_commit, 1'b0);
    tick();
    check("st_commit", commit_valid, 1'b1);
    check("st_store", store_commit, 1'b1);
    check("st_rw", commit_regwrite, 1'b0);
    check("st_free_v", free_valid, 1'b0);
    check("st_pc", commit_pc, 32'h404);
    tick();
    check("st_after", commit_valid, 1'b0);

    // reset mid-operation discards a ready-to-commit entry
    do_alloc(5'd4, 6'd12, 6'd13, 1'b1, 1'b0, 32'h500);
    do_complete(4'd2);
    RESET = 1'b0;
    #1;
    check("rst_count", count, 5'd0);
    check("rst_tag", alloc_tag, 4'd0);
    tick();
    check("rst_commit", commit_valid, 1'b0);
    RESET = 1'b1;
    tick();
    check("rst_after_commit", commit_valid, 1'b0);
    check("rst_after_ready", alloc_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
